mips_multicycle_ctrl: RTL

//  Moore FSM that sequences a multicycle MIPS datapath sharing one unified memory port for fetch and data.

---
 rtl/mips_multicycle_ctrl_pkg.sv | 94 +++++++++
 rtl/mips_funct_dec.sv | 23 ++
 rtl/mips_multicycle_ctrl.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, functs, mux selects,
// FSM states and the registered control word.
package mips_multicycle_ctrl_pkg;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpJal   = 6'b000011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpAddiu = 6'b001001;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpLui   = 6'b001111;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;

  localparam logic [5:0] FnAdd  = 6'b100000;
  localparam logic [5:0] FnAddu = 6'b100001;
  localparam logic [5:0] FnSub  = 6'b100010;
  localparam logic [5:0] FnSubu = 6'b100011;
  localparam logic [5:0] FnAnd  = 6'b100100;
  localparam logic [5:0] FnOr   = 6'b100101;
  localparam logic [5:0] FnSlt  = 6'b101010;
  localparam logic [5:0] FnSltu = 6'b101011;

  localparam logic [2:0] AluAnd = 3'b000;
  localparam logic [2:0] AluOr  = 3'b001;
  localparam logic [2:0] AluAdd = 3'b010;
  localparam logic [2:0] AluSub = 3'b110;
  localparam logic [2:0] AluSlt = 3'b111;

  localparam logic [1:0] SrcBReg   = 2'b00;
  localparam logic [1:0] SrcBFour  = 2'b01;
  localparam logic [1:0] SrcBImm   = 2'b10;
  localparam logic [1:0] SrcBBrOff = 2'b11;

  localparam logic [1:0] PcAlu    = 2'b00;
  localparam logic [1:0] PcAluOut = 2'b01;
  localparam logic [1:0] PcJump   = 2'b10;

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAdr,
    StMemRd,
    StMemWb,
    StMemWr,
    StExec,
    StAluWb,
    StIExec,
    StIWb,
    StBranch,
    StJump,
    StJal,
    StHalt
  } state_e;

  // pc_write is the unconditional PC load; branch/nez qualify it with the ALU zero flag.
  typedef struct packed {
    logic       mem_req;
    logic       memwrite;
    logic       iord;
    logic       irwrite;
    logic       pc_write;
    logic       branch;
    logic       nez;
    logic [1:0] pcsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [2:0] alucontrol;
    logic       signext;
    logic       shiftl16;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       link;
    logic       halted;
  } ctrl_t;

  function automatic state_e decode_next(input logic [5:0] opc);
    state_e s;
    case (opc)
      OpLw, OpSw:                    s = StMemAdr;
      OpRtype:                       s = StExec;
      OpBeq, OpBne:                  s = StBranch;
      OpAddi, OpAddiu, OpOri, OpLui: s = StIExec;
      OpJ:                           s = StJump;
      OpJal:                         s = StJal;
      default:                       s = StHalt;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mips_funct_dec.sv
// R-type funct decoder: maps funct to an ALU operation and flags unsupported functs.
module mips_funct_dec
  import mips_multicycle_ctrl_pkg::*;
(
  input  logic [5:0] funct_i,
  output logic [2:0] alucontrol_o,
  output logic       illegal_o
);

  always_comb begin
    alucontrol_o = AluAdd;
    illegal_o    = 1'b0;
    case (funct_i)
      FnAdd, FnAddu: alucontrol_o = AluAdd;
      FnSub, FnSubu: alucontrol_o = AluSub;
      FnAnd:         alucontrol_o = AluAnd;
      FnOr:          alucontrol_o = AluOr;
      FnSlt, FnSltu: alucontrol_o = AluSlt;
      default:       illegal_o    = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Moore controller for a multicycle MIPS datapath with a single shared req/ready memory port.
// Control word is registered from the next state; only the memory/branch qualifiers are combinational.
module mips_multicycle_ctrl
  import mips_multicycle_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 0,
  parameter int unsigned CNT_W       = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       memwrite,
  output logic       iord,
  output logic       irwrite,
  output logic       pc_en,
  output logic [1:0] pcsrc,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [2:0] alucontrol,
  output logic       signext,
  output logic       shiftl16,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       link,
  output logic       halted,
  output logic       bus_err
);

  localparam bit TimeoutEn = (MEM_TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bus_err_q, bus_err_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic             mem_wait;
  logic [2:0]       funct_alu;
  logic             funct_ill;

  mips_funct_dec u_funct_dec (
    .funct_i      (funct),
    .alucontrol_o (funct_alu),
    .illegal_o    (funct_ill)
  );

  function automatic ctrl_t ctrl_of(input state_e s, input logic [5:0] opc,
                                    input logic [2:0] falu);
    ctrl_t c;
    c            = '0;
    c.alucontrol = AluAdd;
    c.pcsrc      = PcAlu;
    c.alusrcb    = SrcBReg;
    case (s)
      StFetch: begin
        c.mem_req = 1'b1;
        c.irwrite = 1'b1;
        c.alusrcb = SrcBFour;
      end
      StDecode: c.alusrcb = SrcBBrOff;
      StMemAdr: begin
        c.alusrca = 1'b1;
        c.alusrcb = SrcBImm;
        c.signext = 1'b1;
      end
      StMemRd: begin
        c.mem_req = 1'b1;
        c.iord    = 1'b1;
      end
      StMemWb: begin
        c.regwrite = 1'b1;
        c.memtoreg = 1'b1;
      end
      StMemWr: begin
        c.mem_req  = 1'b1;
        c.memwrite = 1'b1;
        c.iord     = 1'b1;
      end
      StExec: begin
        c.alusrca    = 1'b1;
        c.alucontrol = falu;
      end
      StAluWb: begin
        c.regwrite = 1'b1;
        c.regdst   = 1'b1;
      end
      StIExec: begin
        c.alusrca = 1'b1;
        c.alusrcb = SrcBImm;
        case (opc)
          OpOri:   c.alucontrol = AluOr;
          OpLui:   c.shiftl16   = 1'b1;
          default: c.signext    = 1'b1;
        endcase
      end
      StIWb: c.regwrite = 1'b1;
      StBranch: begin
        c.alusrca    = 1'b1;
        c.alucontrol = AluSub;
        c.pcsrc      = PcAluOut;
        c.branch     = 1'b1;
        c.nez        = (opc == OpBne);
      end
      StJump: begin
        c.pcsrc    = PcJump;
        c.pc_write = 1'b1;
      end
      StJal: begin
        c.pcsrc    = PcJump;
        c.pc_write = 1'b1;
        c.regwrite = 1'b1;
        c.link     = 1'b1;
      end
      default: c.halted = 1'b1;
    endcase
    return c;
  endfunction

  always_comb begin
    state_d   = state_q;
    bus_err_d = bus_err_q;
    mem_wait  = 1'b0;
    case (state_q)
      StFetch: begin
        if (mem_ready) state_d = StDecode;
        else           mem_wait = 1'b1;
      end
      StDecode: state_d = decode_next(op);
      StMemAdr: state_d = (op == OpSw) ? StMemWr : StMemRd;
      StMemRd: begin
        if (mem_ready) state_d = StMemWb;
        else           mem_wait = 1'b1;
      end
      StMemWr: begin
        if (mem_ready) state_d = StFetch;
        else           mem_wait = 1'b1;
      end
      StExec:  state_d = funct_ill ? StHalt : StAluWb;
      StIExec: state_d = StIWb;
      StMemWb, StAluWb, StIWb, StBranch, StJump, StJal: state_d = StFetch;
      default: state_d = StHalt;
    endcase

    // A ready on the last allowed wait cycle completes normally; only a miss expires.
    if (TimeoutEn && mem_wait && (cnt_q == TimeoutLast)) begin
      state_d   = StHalt;
      bus_err_d = 1'b1;
    end

    if (state_d != state_q) cnt_d = '0;
    else if (mem_wait)      cnt_d = cnt_q + CNT_W'(1);
    else                    cnt_d = cnt_q;

    ctrl_d = ctrl_of(state_d, op, funct_alu);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StFetch;
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
      ctrl_q    <= ctrl_of(StFetch, op, funct_alu);
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
      ctrl_q    <= ctrl_d;
    end
  end

  // Enables are squashed while reset is held so an abandoned access never commits.
  assign mem_req    = reset & ctrl_q.mem_req;
  assign memwrite   = reset & ctrl_q.memwrite;
  assign irwrite    = reset & ctrl_q.irwrite & mem_ready;
  assign pc_en      = reset & (ctrl_q.pc_write | (ctrl_q.irwrite & mem_ready) |
                               (ctrl_q.branch & (zero ^ ctrl_q.nez)));
  assign regwrite   = reset & ctrl_q.regwrite;
  assign iord       = ctrl_q.iord;
  assign pcsrc      = ctrl_q.pcsrc;
  assign alusrca    = ctrl_q.alusrca;
  assign alusrcb    = ctrl_q.alusrcb;
  assign alucontrol = ctrl_q.alucontrol;
  assign signext    = ctrl_q.signext;
  assign shiftl16   = ctrl_q.shiftl16;
  assign regdst     = ctrl_q.regdst;
  assign memtoreg   = ctrl_q.memtoreg;
  assign link       = ctrl_q.link;
  assign halted     = ctrl_q.halted;
  assign bus_err    = bus_err_q;

endmodule
